mem_bus_arbiter: RTL and testbench
==================================

Name: mem_bus_arbiter

Overview:
- Shares one `memory_bus` (the memory system's CONSUMER side) between `NUM_REQ` requesters, e.g. CPU data port, blitter/DMA and boot loader.
- Round-robin grant, one transaction outstanding at a time.
- Latches the winner's command, pulses dispatch for exactly one cycle, waits for `busy` to drop, then returns read data and a per-requester done pulse.
- Sits between the core/peripherals and `memory_system`.

Parameters:
- `NUM_REQ`, 2, number of requesters (2..4).
- `IDX_W`, `$clog2(NUM_REQ)`, grant index width (derived, not overridden).

Ports:
- `clk_in`  input  1  system clock.
- `rst_in`  input  1  synchronous active-high reset.
- `req_valid`  input  `NUM_REQ`  requester i has a command pending; held until its `done` pulse.
- `req_we`  input  `NUM_REQ`  1 = write, 0 = read.
- `req_addr`  input  `NUM_REQ`x32  byte address.
- `req_wdata`  input  `NUM_REQ`x32  write data.
- `req_width`  input  `NUM_REQ`x`mem::mem_width_t`  access width.
- `req_done`  output  `NUM_REQ`  one-cycle completion pulse to requester i.
- `rd_data`  output  32  read data; valid in the `req_done` cycle.
- `grant_idx`  output  `IDX_W`  index currently/last granted.
- `arb_busy`  output  1  transaction in flight.
- `bus`  interface  -  `memory_bus.CONSUMER` toward the memory system.

Behaviour:
- Clock is `clk_in`; reset `rst_in` is synchronous, active-high. Single clock domain.
- Reset values:
  - state IDLE; `req_done` 0; `rd_data` 0; `grant_idx` 0; `arb_busy` 0.
  - `bus.dispatch_read`/`bus.dispatch_write` 0; `bus.addr`/`bus.write_data` 0; `bus.mem_width` BYTE.
  - RR pointer 0.
- State IDLE:
  - If any `req_valid` is set, pick the first set bit scanning from `(last_grant+1) mod NUM_REQ` upward with wraparound.
  - Latch that requester's addr/wdata/width/we into `bus.*` registers, set `grant_idx`, go to ISSUE.
  - No valid requests: stay in IDLE.
- State ISSUE (1 cycle):
  - Assert exactly one of `dispatch_read` (we=0) or `dispatch_write` (we=1).
  - Go to WAIT. Dispatch is deasserted in WAIT.
- State WAIT:
  - Wait until `bus.busy`=0. `busy` is already high during ISSUE, so the first WAIT cycle never sees a false idle.
  - On `busy`=0: for reads, capture `bus.read_data` into `rd_data`; for writes, leave `rd_data` unchanged.
  - Pulse `req_done[grant_idx]` for one cycle, set `last_grant`=`grant_idx`, go to IDLE.
  - Minimum latency: request seen in IDLE at cycle 0, done pulse no earlier than cycle 3.
- Back-to-back: a requester's `req_valid` is still high in the done cycle. The IDLE cycle after the done pulse re-arbitrates, and RR guarantees another pending requester wins first.
- `bus.addr`/`write_data`/`mem_width` stay stable from ISSUE through the end of WAIT.
- A requester dropping `req_valid` mid-transaction is ignored: the transaction completes and `done` still pulses. A requester must not change its command fields while valid.
- `arb_busy` = (state != IDLE).
- Reset mid-transaction: return to IDLE next edge. No done pulse. `rd_data` cleared. The memory system shares `rst_in`, so no cleanup is needed.
- `NUM_REQ`=1 degenerates to pass-through with identical latency.

Optional Feature:
- Macro: `MEM_ARB_STATS_EN`.
- Defined:
  - Adds output `grant_count` (`NUM_REQ`x16): per-requester completed-transaction counters, incremented in the `req_done` cycle, saturating at 16'hFFFF, cleared on reset.
  - Adds output `wait_cycles` (32): counts cycles where some `req_valid` is high and not yet granted; saturating.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Package `mem` gains:
  - `arb_state_t` enum: IDLE, ISSUE, WAIT.
  - Constant `MEM_ARB_MAX_REQ` = 4.
- Reuses `mem::mem_width_t`.
- One natural sub-module: `rr_priority_picker`. Combinational in, registered pointer inside: inputs request vector and last grant; outputs grant index and found flag.

Test Plan:
- Single read: req0 read addr 32'h0001_0010 width DWORD; model returns 32'hCAFE_F00D after 5 busy cycles -> one-cycle `dispatch_read`, `req_done`=2'b01, `rd_data`=32'hCAFE_F00D, `dispatch_write` never high.
- Contention: req0 and req1 valid simultaneously from reset -> grant order 0,1,0,1 over 4 transactions; each `done` is a one-hot pulse.
- Write then hold: req1 write 32'h0000_ABCD to 32'h0002_0004 width WORD -> `bus.write_data`/`addr`/`width` stable until `busy` falls; `rd_data` retains its prior value.
- Busy stretch: model holds `busy` high 40 cycles -> no second dispatch, `arb_busy`=1 throughout, done exactly once.
- Reset mid-WAIT: assert `rst_in` 1 cycle during WAIT -> next cycle `req_done`=0, `rd_data`=0, state IDLE; a pending request is re-dispatched afterwards.
- `MEM_ARB_STATS_EN`: 3 req0 + 2 req1 transactions -> `grant_count[0]`=3, `grant_count[1]`=2.

Source files
------------

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared memory-system types: access widths, arbiter FSM states and arbiter limits.
package mem;

  typedef enum logic [1:0] {
    BYTE  = 2'd0,
    WORD  = 2'd1,
    DWORD = 2'd2
  } mem_width_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } arb_state_t;

  localparam int MEM_ARB_MAX_REQ = 4;

  // A single requester still needs a one-bit index so port widths never collapse to zero.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/memory_bus.sv
// Command/response bus between a memory consumer (arbiter) and the memory system.
interface memory_bus;
  import mem::*;

  logic        dispatch_read;
  logic        dispatch_write;
  logic [31:0] addr;
  logic [31:0] write_data;
  mem_width_t  mem_width;
  logic        busy;
  logic [31:0] read_data;

  modport CONSUMER (
    output dispatch_read, dispatch_write, addr, write_data, mem_width,
    input  busy, read_data
  );

  modport PROVIDER (
    input  dispatch_read, dispatch_write, addr, write_data, mem_width,
    output busy, read_data
  );

endinterface

// File: rtl/mem_bus_arbiter_rr_priority_picker.sv
// Round-robin picker: scans the request vector from the slot after the last completed grant.
module rr_priority_picker #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               update,
  input  logic [IDX_W-1:0]   update_idx,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               found
);

  logic [IDX_W-1:0] ptr;
  logic [IDX_W:0]   cand;

  // ptr holds the first slot to scan; reset 0 so requester 0 wins the first contention.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (update) begin
      ptr <= (update_idx == IDX_W'(NUM_REQ - 1)) ? '0 : update_idx + 1'b1;
    end
  end

  always_comb begin
    grant_idx = '0;
    found     = 1'b0;
    cand      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = {1'b0, ptr} + (IDX_W + 1)'(i);
      if (cand >= (IDX_W + 1)'(NUM_REQ)) begin
        cand = cand - (IDX_W + 1)'(NUM_REQ);
      end
      if (!found && req[cand[IDX_W-1:0]]) begin
        found     = 1'b1;
        grant_idx = cand[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one memory_bus among NUM_REQ requesters, one transaction at a time.
// Define MEM_ARB_STATS_EN to add grant_count/wait_cycles statistics outputs.
module mem_bus_arbiter
  import mem::*;
#(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = idx_width(NUM_REQ)
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ-1:0]       req_we,
  input  logic [NUM_REQ-1:0][31:0] req_addr,
  input  logic [NUM_REQ-1:0][31:0] req_wdata,
  input  mem_width_t [NUM_REQ-1:0] req_width,
  output logic [NUM_REQ-1:0]       req_done,
  output logic [31:0]              rd_data,
  output logic [IDX_W-1:0]         grant_idx,
  output logic                     arb_busy,
  memory_bus.CONSUMER              bus
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [NUM_REQ-1:0][15:0] grant_count,
  output logic [31:0]              wait_cycles
`endif
);

  arb_state_t       state;
  logic             we_q;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_found;
  logic             finish;

  assign finish   = (state == WAIT) && !bus.busy;
  assign arb_busy = (state != IDLE);

  rr_priority_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .clk        (clk_in),
    .rst        (rst_in),
    .req        (req_valid),
    .update     (finish),
    .update_idx (grant_idx),
    .grant_idx  (pick_idx),
    .found      (pick_found)
  );

  // The done cycle is a dead IDLE cycle: the finished requester still shows valid there,
  // so arbitration waits one cycle for it to drop.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state              <= IDLE;
      req_done           <= '0;
      rd_data            <= '0;
      grant_idx          <= '0;
      we_q               <= 1'b0;
      bus.dispatch_read  <= 1'b0;
      bus.dispatch_write <= 1'b0;
      bus.addr           <= '0;
      bus.write_data     <= '0;
      bus.mem_width      <= BYTE;
    end else begin
      req_done <= '0;
      case (state)
        IDLE: begin
          if (pick_found && (req_done == '0)) begin
            bus.addr           <= req_addr[pick_idx];
            bus.write_data     <= req_wdata[pick_idx];
            bus.mem_width      <= req_width[pick_idx];
            bus.dispatch_read  <= ~req_we[pick_idx];
            bus.dispatch_write <= req_we[pick_idx];
            we_q               <= req_we[pick_idx];
            grant_idx          <= pick_idx;
            state              <= ISSUE;
          end
        end
        ISSUE: begin
          bus.dispatch_read  <= 1'b0;
          bus.dispatch_write <= 1'b0;
          state              <= WAIT;
        end
        WAIT: begin
          if (!bus.busy) begin
            if (!we_q) begin
              rd_data <= bus.read_data;
            end
            req_done[grant_idx] <= 1'b1;
            state               <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MEM_ARB_STATS_EN
  logic waiting;

  // A requester is waiting while valid and not the one currently being served.
  always_comb begin
    waiting = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_valid[i] && !req_done[i] && !(arb_busy && (grant_idx == IDX_W'(i)))) begin
        waiting = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      grant_count <= '0;
      wait_cycles <= '0;
    end else begin
      if (finish && (grant_count[grant_idx] != 16'hFFFF)) begin
        grant_count[grant_idx] <= grant_count[grant_idx] + 16'd1;
      end
      if (waiting && (wait_cycles != 32'hFFFF_FFFF)) begin
        wait_cycles <= wait_cycles + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: requester drivers queue expected transactions,
// a memory responder answers the bus, and a monitor checks every dispatch and completion.
module tb_mem_bus_arbiter;
  import mem::*;

  localparam int NUM_REQ = 2;
  localparam int IDX_W   = 1;
  localparam int TIMEOUT = 400;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    mem_width_t  width;
  } txn_t;

  logic                     clk_in = 1'b0;
  logic                     rst_in = 1'b1;
  logic [NUM_REQ-1:0]       req_valid = '0;
  logic [NUM_REQ-1:0]       req_we = '0;
  logic [NUM_REQ-1:0][31:0] req_addr = '0;
  logic [NUM_REQ-1:0][31:0] req_wdata = '0;
  mem_width_t [NUM_REQ-1:0] req_width;
  logic [NUM_REQ-1:0]       req_done;
  logic [31:0]              rd_data;
  logic [IDX_W-1:0]         grant_idx;
  logic                     arb_busy;
`ifdef MEM_ARB_STATS_EN
  logic [NUM_REQ-1:0][15:0] grant_count;
  logic [31:0]              wait_cycles;
`endif

  memory_bus bus_if ();

  mem_bus_arbiter #(.NUM_REQ(NUM_REQ)) dut (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .req_valid (req_valid),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_width (req_width),
    .req_done  (req_done),
    .rd_data   (rd_data),
    .grant_idx (grant_idx),
    .arb_busy  (arb_busy),
    .bus       (bus_if)
`ifdef MEM_ARB_STATS_EN
    ,
    .grant_count (grant_count),
    .wait_cycles (wait_cycles)
`endif
  );

  always #5 clk_in = ~clk_in;

  int check_count = 0;
  int pass_count  = 0;
  int issued_count = 0;
  int done_count  = 0;

  txn_t        expq [NUM_REQ][$];
  logic [31:0] shadow    [0:1023] = '{default: 32'h0};
  logic [31:0] mem_store [0:1023] = '{default: 32'h0};

  // Unwritten memory reads back an address-derived pattern; one boot word holds CAFE_F00D.
  function automatic logic [31:0] mem_seed(input logic [31:0] a);
    if (a == 32'h0001_0010) return 32'hCAFE_F00D;
    return {a[15:0], ~a[15:0]};
  endfunction

  function automatic logic [9:0] mem_idx(input logic [31:0] a);
    return {a[29:28], a[9:2]};
  endfunction

  function automatic int predict_winner(input logic [NUM_REQ-1:0] v, input int start);
    for (int k = 0; k < NUM_REQ; k++) begin
      if (v[(start + k) % NUM_REQ]) return (start + k) % NUM_REQ;
    end
    return -1;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    check_count++;
    if (actual !== expected) begin
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end else begin
      pass_count++;
    end
  endtask

  // Memory responder: busy rises with dispatch and stays high for the chosen latency.
  int          busy_cnt = 0;
  int          forced_lat = 0;
  int          issued_lat = 0;
  int          rand_lat = 1;
  int          cur_lat;
  logic [31:0] rd_reg = '0;

  assign cur_lat           = (forced_lat != 0) ? forced_lat : rand_lat;
  assign bus_if.busy       = bus_if.dispatch_read | bus_if.dispatch_write | (busy_cnt != 0);
  assign bus_if.read_data  = rd_reg;

  always @(negedge clk_in) rand_lat <= int'($urandom_range(1, 6));

  always @(posedge clk_in) begin
    if (rst_in) begin
      busy_cnt <= 0;
      rd_reg   <= '0;
    end else if (bus_if.dispatch_read || bus_if.dispatch_write) begin
      busy_cnt   <= cur_lat;
      issued_lat <= cur_lat;
      if (bus_if.dispatch_write) begin
        mem_store[mem_idx(bus_if.addr)] <= bus_if.write_data ^ mem_seed(bus_if.addr);
      end else begin
        rd_reg <= mem_store[mem_idx(bus_if.addr)] ^ mem_seed(bus_if.addr);
      end
    end else if (busy_cnt > 0) begin
      busy_cnt <= busy_cnt - 1;
    end
  end

  logic [NUM_REQ-1:0] smp_valid = '0;
  logic               smp_rst = 1'b0;
  always @(posedge clk_in) begin
    smp_valid <= req_valid;
    smp_rst   <= rst_in;
  end

  // Monitor: reference arbitration from the pending set and the round-robin start slot.
  initial begin
    int   cyc;
    int   model_ptr;
    int   winner;
    int   cur_idx;
    int   issue_cyc;
    logic inflight;
    logic [31:0] model_rd;
    txn_t cur;
    cyc = 0; model_ptr = 0; inflight = 1'b0; model_rd = '0; cur_idx = 0; issue_cyc = 0;
    forever begin
      @(posedge clk_in);
      #1;
      cyc++;
      if (smp_rst) begin
        checkOutput("rst_req_done", 32'(req_done), 32'h0);
        checkOutput("rst_rd_data", rd_data, 32'h0);
        checkOutput("rst_arb_busy", 32'(arb_busy), 32'h0);
        checkOutput("rst_grant_idx", 32'(grant_idx), 32'h0);
        checkOutput("rst_dispatch", {30'h0, bus_if.dispatch_read, bus_if.dispatch_write}, 32'h0);
        checkOutput("rst_mem_width", 32'(bus_if.mem_width), 32'(BYTE));
        inflight = 1'b0; model_ptr = 0; model_rd = '0;
      end else begin
        if (bus_if.dispatch_read || bus_if.dispatch_write) begin
          if (inflight) begin
            checkOutput("dispatch_while_busy", 32'h1, 32'h0);
          end else begin
            winner = predict_winner(smp_valid, model_ptr);
            if (winner < 0) begin
              checkOutput("dispatch_without_request", 32'h1, 32'h0);
            end else if (expq[winner].size() == 0) begin
              checkOutput("dispatch_no_expectation", 32'(winner), 32'hFFFF_FFFF);
            end else begin
              cur = expq[winner][0];
              checkOutput("grant_idx", 32'(grant_idx), 32'(winner));
              checkOutput("dispatch_kind", {30'h0, bus_if.dispatch_read, bus_if.dispatch_write},
                          cur.we ? 32'h1 : 32'h2);
              checkOutput("issue_addr", bus_if.addr, cur.addr);
              checkOutput("issue_wdata", bus_if.write_data, cur.wdata);
              checkOutput("issue_width", 32'(bus_if.mem_width), 32'(cur.width));
              checkOutput("issue_arb_busy", 32'(arb_busy), 32'h1);
              inflight = 1'b1; cur_idx = winner; issue_cyc = cyc;
            end
          end
        end else if (inflight && (req_done == '0)) begin
          checkOutput("wait_arb_busy", 32'(arb_busy), 32'h1);
          checkOutput("wait_addr_stable", bus_if.addr, cur.addr);
          checkOutput("wait_wdata_stable", bus_if.write_data, cur.wdata);
          checkOutput("wait_width_stable", 32'(bus_if.mem_width), 32'(cur.width));
          checkOutput("wait_grant_idx", 32'(grant_idx), 32'(cur_idx));
        end
        if (req_done != '0) begin
          if (!inflight) begin
            checkOutput("spurious_done", 32'(req_done), 32'h0);
          end else begin
            checkOutput("done_onehot", 32'(req_done), 32'h1 << cur_idx);
            checkOutput("done_latency", 32'(cyc - issue_cyc), 32'(issued_lat + 2));
            if (!cur.we) model_rd = cur.rdata;
            checkOutput("done_rd_data", rd_data, model_rd);
            checkOutput("done_arb_busy", 32'(arb_busy), 32'h0);
            void'(expq[cur_idx].pop_front());
            model_ptr = (cur_idx + 1) % NUM_REQ;
            inflight  = 1'b0;
            done_count++;
          end
        end
      end
    end
  end

  task automatic applyStimulus(input int r, input logic we, input logic [31:0] addr,
                               input logic [31:0] wdata, input mem_width_t width);
    txn_t t;
    int   wait_cnt;
    @(negedge clk_in);
    t.we    = we;
    t.addr  = addr;
    t.wdata = wdata;
    t.width = width;
    t.rdata = we ? 32'h0 : (shadow[mem_idx(addr)] ^ mem_seed(addr));
    if (we) shadow[mem_idx(addr)] = wdata ^ mem_seed(addr);
    expq[r].push_back(t);
    issued_count++;
    req_we[r]    = we;
    req_addr[r]  = addr;
    req_wdata[r] = wdata;
    req_width[r] = width;
    req_valid[r] = 1'b1;
    wait_cnt = 0;
    while ((req_done[r] !== 1'b1) && (wait_cnt < TIMEOUT)) begin
      @(negedge clk_in);
      wait_cnt++;
    end
    if (wait_cnt >= TIMEOUT) begin
      checkOutput($sformatf("done_timeout_req%0d", r), 32'h0, 32'h1);
      expq[r].delete();
    end
    req_valid[r] = 1'b0;
  endtask

  task automatic doReset();
    @(negedge clk_in);
    rst_in = 1'b1;
    repeat (2) @(negedge clk_in);
    rst_in = 1'b0;
  endtask

  task automatic randomTraffic(input int r, input int n);
    for (int k = 0; k < n; k++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk_in);
      applyStimulus(r, 1'($urandom_range(0, 1)),
                    (32'h1000_0000 * (r + 1)) | (32'($urandom_range(0, 7)) << 2),
                    $urandom, mem_width_t'($urandom_range(0, 2)));
    end
  endtask

  initial begin
    for (int i = 0; i < NUM_REQ; i++) req_width[i] = BYTE;
    repeat (3) @(negedge clk_in);
    rst_in = 1'b0;

    // Contention from reset: both requesters, two reads each, must alternate 0,1,0,1.
    doReset();
    fork
      begin
        applyStimulus(0, 1'b0, 32'h1000_0000, 32'h0, DWORD);
        applyStimulus(0, 1'b0, 32'h1000_0004, 32'h0, DWORD);
      end
      begin
        applyStimulus(1, 1'b0, 32'h2000_0000, 32'h0, WORD);
        applyStimulus(1, 1'b0, 32'h2000_0004, 32'h0, WORD);
      end
    join

    forced_lat = 5;
    applyStimulus(0, 1'b0, 32'h0001_0010, 32'h0, DWORD);
    forced_lat = 3;
    applyStimulus(1, 1'b1, 32'h0002_0004, 32'h0000_ABCD, WORD);

    forced_lat = 40;
    applyStimulus(1, 1'b0, 32'h2000_0010, 32'h0, DWORD);

    // Reset pulse while the transaction sits in WAIT; the held request must be re-dispatched.
    forced_lat = 12;
    fork
      applyStimulus(0, 1'b0, 32'h1000_0040, 32'h0, DWORD);
      begin
        int n;
        n = 0;
        @(negedge clk_in);
        while (!((arb_busy === 1'b1) && (bus_if.dispatch_read === 1'b0)) && (n < 50)) begin
          @(negedge clk_in);
          n++;
        end
        if (n >= 50) checkOutput("reach_wait_timeout", 32'h0, 32'h1);
        repeat (2) @(negedge clk_in);
        rst_in = 1'b1;
        @(negedge clk_in);
        rst_in = 1'b0;
      end
    join

    forced_lat = 0;
    fork
      randomTraffic(0, 15);
      randomTraffic(1, 15);
    join

`ifdef MEM_ARB_STATS_EN
    doReset();
    repeat (3) applyStimulus(0, 1'b0, 32'h1000_0080, 32'h0, BYTE);
    repeat (2) applyStimulus(1, 1'b1, 32'h2000_0080, 32'h1234_5678, BYTE);
    @(negedge clk_in);
    checkOutput("grant_count0", 32'(grant_count[0]), 32'd3);
    checkOutput("grant_count1", 32'(grant_count[1]), 32'd2);
`endif

    repeat (5) @(negedge clk_in);
    checkOutput("done_count", 32'(done_count), 32'(issued_count));
    checkOutput("final_idle", 32'(arb_busy), 32'h0);
    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] simulation did not finish");
  end

endmodule
